// File: rtl/cube_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cube_pkg
//  Description : Shared constants, state/colour enums and the corner-sticker
//                bit-position table for the corner scan path.
//  Revision    : 1.0  initial release
// ============================================================================
package cube_pkg;

    localparam int CUBE_W          = 162;  // 54 stickers x 3 bits
    localparam int COLOR_W         = 3;
    localparam int N_CORNER        = 24;
    localparam int CORNER_IDX_BASE = 24;   // corner entries live at ROM addr 24..47
    localparam int N_COLOR         = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        EMIT   = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    typedef enum logic [2:0] {
        COL_U = 3'd0,
        COL_R = 3'd1,
        COL_F = 3'd2,
        COL_D = 3'd3,
        COL_L = 3'd4,
        COL_B = 3'd5
    } color_t;

    // LSB bit index (3 x facelet) of each corner sticker in learn order:
    // DFR, DBR, DBL, DFL, UFR, UBR, UFL, UBL (three stickers per corner,
    // U/D face first, then F/B, then R/L).
    localparam logic [7:0] CORNER_POS [0:N_CORNER-1] = '{
        8'd87,  8'd78,  8'd45,    // DFR : D3 F9 R7
        8'd105, 8'd153, 8'd51,    // DBR : D9 B7 R9
        8'd99,  8'd159, 8'd126,   // DBL : D7 B9 L7
        8'd81,  8'd72,  8'd132,   // DFL : D1 F7 L9
        8'd24,  8'd60,  8'd27,    // UFR : U9 F3 R1
        8'd6,   8'd135, 8'd33,    // UBR : U3 B1 R3
        8'd18,  8'd54,  8'd114,   // UFL : U7 F1 L3
        8'd0,   8'd141, 8'd108    // UBL : U1 B3 L1
    };

endpackage
`default_nettype wire

// File: rtl/corner_pos_rom.sv
`default_nettype none
// ============================================================================
//  Module      : corner_pos_rom
//  Description : Registered lookup from ROM address to sticker bit position.
//                Addresses outside the corner window read as 0.
//  Revision    : 1.0  initial release
// ============================================================================
module corner_pos_rom
    import cube_pkg::*;
(
    input  logic       clock,
    input  logic [5:0] addr,
    output logic [7:0] pos
);

    logic [7:0] pos_next;

    // Decode the corner window; everything else falls to the zero default.
    always_comb begin
        pos_next = 8'd0;
        for (int k = 0; k < N_CORNER; k++) begin
            if (addr == 6'(CORNER_IDX_BASE + k)) begin
                pos_next = CORNER_POS[k];
            end
        end
    end

    // ROM output register: position is valid one cycle after the address.
    always_ff @(posedge clock) begin
        pos <= pos_next;
    end

endmodule
`default_nettype wire

// File: rtl/corner_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : corner_scan_ctrl
//  Description : Snapshots the cubestate on start and streams the 24 corner
//                sticker colours in learn order over a valid/ready port.
//                Optional colour sanity check: CORNER_COLOR_CHECK_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module corner_scan_ctrl
    import cube_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [CUBE_W-1:0]  cubestate,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_idx,
    output logic [COLOR_W-1:0] out_color,
    output logic               done,
    output logic               color_err
);

    scan_state_t       state;
    logic [CUBE_W-1:0] snap;
    logic [4:0]        idx;
    logic [5:0]        rom_addr;
    logic [7:0]        pos;

    assign rom_addr = {1'b0, idx} + 6'(CORNER_IDX_BASE);

    corner_pos_rom u_rom (
        .clock (clock),
        .addr  (rom_addr),
        .pos   (pos)
    );

    // Colour is selected straight from the snapshot by the registered
    // position, so it is ready in the same cycle EMIT raises valid.
    assign out_color = out_valid ? snap[pos +: COLOR_W] : '0;
    assign out_idx   = idx;

    // Scan sequencer with registered busy/valid/done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            snap      <= '0;
            idx       <= 5'd0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // start outranks a simultaneous abort here
                    if (start) begin
                        snap  <= cubestate;
                        idx   <= 5'd0;
                        busy  <= 1'b1;
                        state <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (idx == 5'(N_CORNER - 1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            idx   <= idx + 5'd1;
                            state <= LOOKUP;
                        end
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

`ifdef CORNER_COLOR_CHECK_EN
    logic [3:0] color_cnt [0:N_COLOR-1];
    logic       color_bad;
    logic       handshake;
    logic       err_next;

    assign handshake = (state == EMIT) && out_ready && !abort;

    // Verdict including the beat being accepted right now.
    always_comb begin
        err_next = color_bad || (out_color > 3'(COL_B));
        for (int k = 0; k < N_COLOR; k++) begin
            if ((color_cnt[k] + ((out_color == 3'(k)) ? 4'd1 : 4'd0)) != 4'd4) begin
                err_next = 1'b1;
            end
        end
    end

    // Per-colour tallies; verdict latched on the final handshake, held
    // until the next start.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < N_COLOR; k++) color_cnt[k] <= 4'd0;
            color_bad <= 1'b0;
            color_err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            for (int k = 0; k < N_COLOR; k++) color_cnt[k] <= 4'd0;
            color_bad <= 1'b0;
            color_err <= 1'b0;
        end else if (handshake) begin
            for (int k = 0; k < N_COLOR; k++) begin
                if (out_color == 3'(k)) color_cnt[k] <= color_cnt[k] + 4'd1;
            end
            if (out_color > 3'(COL_B)) color_bad <= 1'b1;
            if (idx == 5'(N_CORNER - 1)) color_err <= err_next;
        end
    end
`else
    assign color_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_corner_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_corner_scan_ctrl
//  Description : Scoreboard bench for corner_scan_ctrl. The reference model
//                works on facelet numbers and the corner learn order.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_corner_scan_ctrl;

    localparam int CW = 162;
    localparam int M_NORMAL = 0, M_STALL = 1, M_RAND = 2, M_CHANGE = 3,
                   M_ABORT = 4, M_RESET = 5;

    // Facelet numbers (U0-8 R9-17 F18-26 D27-35 L36-44 B45-53) in learn order.
    localparam int FAC [0:23] = '{29, 26, 15,  35, 51, 17,  33, 53, 42,  27, 24, 44,
                                  8, 20, 9,    2, 45, 11,   6, 18, 38,   0, 47, 36};

    logic          clock = 1'b0;
    logic          reset, start, abort, out_ready;
    logic [CW-1:0] cubestate;
    logic          busy, out_valid, done, color_err;
    logic [4:0]    out_idx;
    logic [2:0]    out_color;

    corner_scan_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .cubestate (cubestate),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_color (out_color),
        .done      (done),
        .color_err (color_err)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct { int idx; int col; } beat_t;
    beat_t exp_q [$];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented beat must equal the scoreboard head; pop on
    // an accepted handshake.
    always @(negedge clock) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 0, 1'b1 ^ out_valid ^ 1'b1 ? 1 : 0);
            end else begin
                chk("beat_idx", out_idx, exp_q[0].idx);
                chk("beat_color", out_color, exp_q[0].col);
                if (out_ready && !abort) void'(exp_q.pop_front());
            end
        end
        if (!reset && done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    function automatic logic [CW-1:0] solved_cube();
        logic [CW-1:0] c;
        c = '0;
        for (int s = 0; s < 54; s++) c[3*s +: 3] = 3'(s / 9);
        return c;
    endfunction

    function automatic logic [CW-1:0] random_cube();
        logic [CW-1:0] c;
        c = '0;
        for (int s = 0; s < 54; s++) c[3*s +: 3] = 3'($urandom_range(0, 7));
        return c;
    endfunction

    task automatic scan(input logic [CW-1:0] cube, input int mode, input int arg);
        int       t0, dstart, stall_left, n;
        bit       stalled, exp_err;
        int       cnt [8];
        logic [2:0] c;
        foreach (cnt[i]) cnt[i] = 0;
        @(posedge clock); #1;
        cubestate = cube;
        start     = 1'b1;
        abort     = (mode == M_RAND);   // start must win over abort in IDLE
        out_ready = 1'b1;
        for (int k = 0; k < 24; k++) begin
            c = cube[3*FAC[k] +: 3];
            exp_q.push_back('{k, int'(c)});
            cnt[c]++;
        end
`ifdef CORNER_COLOR_CHECK_EN
        exp_err = (cnt[6] + cnt[7]) != 0;
        for (int k = 0; k < 6; k++) if (cnt[k] != 4) exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        t0     = cyc;
        dstart = done_cnt;
        @(posedge clock); #1;
        start = 1'b0;
        abort = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("err_clear_at_start", color_err, 0);
        stalled    = 1'b0;
        stall_left = 0;
        for (n = 0; n < 400; n++) begin
            if (done_cnt != dstart) break;
            if (mode == M_NORMAL && cyc == t0 + 1) chk("valid_low_in_lookup", out_valid, 0);
            if (mode == M_NORMAL && cyc == t0 + 2) chk("first_valid_latency", out_valid, 1);
            if (mode == M_CHANGE && cyc == t0 + 3) cubestate = {54{3'd2}};
            if (mode == M_RAND) begin
                out_ready = 1'($urandom_range(0, 1));
                start     = 1'($urandom_range(0, 1));
                cubestate = random_cube();
            end
            if (mode == M_STALL) begin
                if (stall_left > 0) begin
                    chk("stall_valid_held", out_valid, 1);
                    stall_left--;
                    if (stall_left == 0) out_ready = 1'b1;
                end else if (!stalled && out_valid && out_idx == 5'(arg)) begin
                    stalled    = 1'b1;
                    stall_left = 5;
                    out_ready  = 1'b0;
                end
            end
            if ((mode == M_ABORT || mode == M_RESET) && out_valid && out_idx == 5'(arg)) begin
                if (mode == M_ABORT) abort = 1'b1;
                else                 reset = 1'b1;
                @(posedge clock); #1;
                abort = 1'b0;
                reset = 1'b0;
                if (mode == M_ABORT) begin
                    chk("abort_beats_left", exp_q.size(), 24 - arg);
                    chk("abort_valid", out_valid, 0);
                    chk("abort_busy", busy, 0);
                end else begin
                    chk("rst_busy", busy, 0);
                    chk("rst_valid", out_valid, 0);
                    chk("rst_idx", out_idx, 0);
                    chk("rst_color", out_color, 0);
                    chk("rst_done", done, 0);
                    chk("rst_err", color_err, 0);
                end
                exp_q.delete();
                repeat (60) @(posedge clock);
                #1;
                chk("no_done_after_cancel", done_cnt, dstart);
                chk("idle_after_cancel", busy, 0);
                return;
            end
            @(posedge clock); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        cubestate = cube;
        chk("scan_completes", done_cnt, dstart + 1);
        if (n >= 400) begin
            reset = 1'b1;
            @(posedge clock); #1;
            reset = 1'b0;
            exp_q.delete();
            return;
        end
        if (mode == M_NORMAL || mode == M_CHANGE) chk("done_latency", last_done_cyc, t0 + 49);
        if (mode == M_STALL) chk("done_latency_stall", last_done_cyc, t0 + 54);
        chk("beats_left", exp_q.size(), 0);
        chk("busy_after_done", busy, 0);
        chk("color_err", color_err, exp_err);
        repeat (2) @(posedge clock);
        #1;
        chk("done_single_pulse", done_cnt, dstart + 1);
        chk("color_err_held", color_err, exp_err);
    endtask

    initial begin
        logic [CW-1:0] bad;
        reset     = 1'b1;
        start     = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b1;
        cubestate = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("reset_busy", busy, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_idx", out_idx, 0);
        chk("reset_color", out_color, 0);
        chk("reset_err", color_err, 0);

        scan(solved_cube(), M_NORMAL, 0);     // plain solved scan
        scan(solved_cube(), M_STALL, 7);      // back-pressure at idx 7
        scan(random_cube(), M_CHANGE, 0);     // snapshot isolation
        scan(solved_cube(), M_ABORT, 10);     // abort in EMIT
        scan(solved_cube(), M_NORMAL, 0);     // replay from idx 0
        scan(solved_cube(), M_RESET, 15);     // reset mid-scan
        scan(random_cube(), M_NORMAL, 0);
        bad = solved_cube();
        bad[3*FAC[3] +: 3] = 3'd7;
        scan(bad, M_NORMAL, 0);               // illegal colour
        scan(solved_cube(), M_NORMAL, 0);     // clears the flag
        repeat (4) scan(random_cube(), M_RAND, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
